uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (byte interface: tx_data / tx_start / tx_busy) among 4 byte-stream requesters, e.g. the keypad/piano event reporter, the picture-display status echo and the seg-display debug channel.
- Arbitration is round-robin and packet-locked. A granted requester keeps the UART until it flags the last byte, reaches the packet byte limit, or stalls past a timeout.
- Sits between the requester modules and the UART TX core in the top level.

Parameters:
- MAX_PKT, 64, maximum bytes sent per grant before forced release (1..255).
- IDLE_TO, 1024, cycles a granted requester may hold valid low before the grant is aborted (≥2).
- GAP_CYCLES, 4, idle cycles inserted after every release before re-arbitration (0 allowed).

Ports:
- clk  in  1  system clock (12 MHz domain).
- rst  in  1  synchronous, active-high reset.
- req_valid  in  4  per-requester byte valid.
- req_data  in  32  packed bytes; requester i on bits [8i+7:8i].
- req_last  in  4  per-requester last-byte-of-packet flag, qualified by req_valid.
- req_ready  out  4  one-cycle accept pulse to the granted requester.
- tx_data  out  8  byte to UART TX core.
- tx_start  out  1  one-cycle start pulse to UART TX core.
- tx_busy  in  1  UART TX busy; rises within 1 cycle of tx_start, falls when the stop bit is done.
- grant  out  4  one-hot current owner; 0 when none.
- pkt_abort  out  1  one-cycle pulse when a grant is released by IDLE_TO.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset: tx_data=0, tx_start=0, req_ready=0, grant=0, pkt_abort=0, rr_ptr=0, byte_cnt=0, idle_cnt=0, gap_cnt=0, state=IDLE.
- Reset mid-packet abandons the packet immediately. No tx_start or req_ready is asserted in the cycle after rst is sampled high.
- All outputs are registered.
- FSM states: IDLE, SEND, HOLD, DRAIN, GAP.
- IDLE:
  - If any req_valid is high, pick the first valid index scanning rr_ptr, rr_ptr+1, ... (mod 4).
  - Register grant (one-hot) and clear byte_cnt and idle_cnt, then go to SEND.
  - Arbitration latency is 1 cycle, from req_valid to grant.
- SEND (grant=g):
  - If req_valid[g]=1 and tx_busy=0: at the next edge, tx_data<=req_data[g], last_q<=req_last[g], tx_start<=1, req_ready[g]<=1 (both for exactly 1 cycle), byte_cnt+1, idle_cnt<=0. Go to HOLD.
  - Producer rule: valid/data/last must stay stable from assertion through the cycle in which req_ready[g]=1. The producer may change them the following cycle.
  - If req_valid[g]=0: idle_cnt+1. When idle_cnt reaches IDLE_TO-1, pulse pkt_abort and release.
- HOLD: 1 cycle, tx_busy ignored (covers the UART start latency). Go to DRAIN.
- DRAIN: wait for tx_busy=0. Then:
  - if last_q=1 or byte_cnt==MAX_PKT, release;
  - otherwise go to SEND.
- Release:
  - grant<=0, rr_ptr<=g+1 (mod 4).
  - If GAP_CYCLES=0, go to IDLE; otherwise go to GAP.
- GAP: count GAP_CYCLES cycles with grant=0, then go to IDLE.
- Fairness: a requester that just released is the lowest priority at the next arbitration. Requests from non-granted requesters are ignored and receive no ready while another owns the UART.
- Simultaneous events:
  - req_last=1 on the MAX_PKT-th byte gives a single release (no double pointer advance).
  - Valid dropping in the same cycle as the accept is a producer violation and undefined.
  - A req_valid change on a non-granted port never affects the current grant.
- byte_cnt is 8-bit saturating, compared against MAX_PKT. idle_cnt width is clog2(IDLE_TO).
- Invariants: at most one tx_start per byte; req_ready is always one-hot or zero and coincides with tx_start.

Test Plan:
- Single byte: req_valid[2]=1, req_data byte2=0x5A, req_last[2]=1 → grant=0100 after 1 cycle. tx_start and req_ready=0100 pulse together with tx_data=0x5A. After tx_busy falls, grant=0 for 4 cycles, then IDLE; rr_ptr=3.
- Round-robin: all four valid with last=1, each sending 1 byte → grant order 0001, 0010, 0100, 1000, 0001, each separated by 4 gap cycles.
- Packet lock and limit: requester 0 streams 70 bytes, last never set, requester 1 valid throughout → exactly 64 bytes from 0, release, requester 1 granted next. Requester 0 regains the UART only after requester 1 releases.
- Stall timeout: requester 3 granted, sends 2 bytes, then drops valid → pkt_abort pulses once after 1024 idle cycles, grant=0, and no further tx_start until re-arbitration.
- Backpressure: model the UART with tx_busy high for 10 cycles per byte and send 3 bytes → tx_start spacing ≥12 cycles, and tx_start is never asserted while tx_busy=1.
- Reset mid-packet: assert rst during DRAIN of byte 2 of 5 → the next cycle shows all outputs 0 and state IDLE. After rst is released, requester 0 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream handshake shared by the requesters, the arbiter and the UART TX core.
// The slave side is the arbiter; the master side is everything around it.
interface uart_tx_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [3:0]  grant;
  logic        pkt_abort;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_start, grant, pkt_abort
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_start, grant, pkt_abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART byte transmitter among 4 requesters.
//   state | meaning
//   IDLE  | no owner; pick next valid requester starting at rr_ptr
//   SEND  | owner granted; launch a byte when it is valid and the UART is free
//   HOLD  | one cycle after tx_start while the UART raises tx_busy
//   DRAIN | wait for tx_busy low, then release or send the next byte
//   GAP   | idle spacing after a release before re-arbitration
module uart_tx_arbiter #(
  parameter int MAX_PKT    = 64,
  parameter int IDLE_TO    = 1024,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IDLE_W = $clog2(IDLE_TO);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TO - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [7:0]        PKT_LIMIT = 8'(MAX_PKT);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    HOLD,
    DRAIN,
    GAP
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          grant_q, grant_d;
  logic [1:0]          owner_q, owner_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [7:0]          byte_cnt_q, byte_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                last_q, last_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic [3:0]          req_ready_q, req_ready_d;
  logic                pkt_abort_q, pkt_abort_d;

  logic                pick_found;
  logic [1:0]          pick_idx;
  logic [1:0]          cand;
  logic                release_now;

  logic                own_valid;
  logic                own_last;
  logic [7:0]          own_data;

  assign own_valid = bus.req_valid[owner_q];
  assign own_last  = bus.req_last[owner_q];
  assign own_data  = bus.req_data[{owner_q, 3'b000} +: 8];

  // Scan from the farthest offset down so the nearest valid index after rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = '0;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr_q + 2'(k);
      if (bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    last_d      = last_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    req_ready_d = 4'b0000;
    pkt_abort_d = 1'b0;
    release_now = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = 4'b0001 << pick_idx;
          owner_d    = pick_idx;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = SEND;
        end
      end

      SEND: begin
        if (own_valid && !bus.tx_busy) begin
          tx_data_d   = own_data;
          last_d      = own_last;
          tx_start_d  = 1'b1;
          req_ready_d = 4'b0001 << owner_q;
          byte_cnt_d  = (byte_cnt_q == 8'hFF) ? byte_cnt_q : byte_cnt_q + 8'd1;
          idle_cnt_d  = '0;
          state_d     = HOLD;
        end else if (!own_valid) begin
          if (idle_cnt_q == IDLE_LAST) begin
            pkt_abort_d = 1'b1;
            release_now = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end

      HOLD: state_d = DRAIN;

      DRAIN: begin
        if (!bus.tx_busy) begin
          if (last_q || (byte_cnt_q == PKT_LIMIT)) begin
            release_now = 1'b1;
          end else begin
            state_d = SEND;
          end
        end
      end

      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Every release path funnels here, so the pointer advances exactly once.
    if (release_now) begin
      grant_d  = 4'b0000;
      rr_ptr_d = owner_q + 2'd1;
      if (GAP_CYCLES == 0) begin
        state_d = IDLE;
      end else begin
        state_d   = GAP;
        gap_cnt_d = GAP_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      last_q      <= 1'b0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
      pkt_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      last_q      <= last_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      req_ready_q <= req_ready_d;
      pkt_abort_q <= pkt_abort_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.req_ready = req_ready_q;
  assign bus.pkt_abort = pkt_abort_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready_q));
  a_ready_with_start: assert property (@(posedge clk) disable iff (rst)
                                       ((req_ready_q != 4'b0000) == tx_start_q));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: behavioural requesters and UART busy model, hand-derived checks.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int busy_len = 3;
  int busy_cnt = 0;

  int        rem[4];
  int        sent[4];
  logic [7:0] seed[4];
  bit        last_every[4];
  bit        last_final[4];

  logic [3:0]  ready_prev = 4'b0;
  logic [3:0]  grant_prev = 4'b0;
  logic [3:0]  v_n;
  logic [3:0]  l_n;
  logic [31:0] d_n;

  int starts, aborts, ready_bad, busy_viol, cur_bytes, zrun;
  int valid_rise_cyc, abort_cyc;
  bit seen_grant;

  logic [3:0] grant_log[$];
  int         grant_cyc[$];
  int         zrun_log[$];
  int         seg_bytes[$];
  int         start_cyc[$];
  logic [7:0] start_data[$];
  logic [3:0] start_ready[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    grant_cyc.delete();
    zrun_log.delete();
    seg_bytes.delete();
    start_cyc.delete();
    start_data.delete();
    start_ready.delete();
    starts     = 0;
    aborts     = 0;
    cur_bytes  = 0;
    zrun       = 0;
    seen_grant = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0; sent[i] = 0; seed[i] = 8'h00;
      last_every[i] = 1'b0; last_final[i] = 1'b0;
    end
    busy_cnt    = 0;
    bus.tx_busy = 1'b0;
    step();
    step();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_starts(int n, int budget, string tag);
    int k = 0;
    while (starts < n && k < budget) begin step(); k++; end
    if (starts < n) chk({tag, "_timeout"}, starts, n);
  endtask

  task automatic wait_segs(int n, int budget, string tag);
    int k = 0;
    while (seg_bytes.size() < n && k < budget) begin step(); k++; end
    if (seg_bytes.size() < n) chk({tag, "_timeout"}, seg_bytes.size(), n);
  endtask

  task automatic wait_grants(int n, int budget, string tag);
    int k = 0;
    while (grant_log.size() < n && k < budget) begin step(); k++; end
    if (grant_log.size() < n) chk({tag, "_timeout"}, grant_log.size(), n);
  endtask

  task automatic wait_aborts(int n, int budget, string tag);
    int k = 0;
    while (aborts < n && k < budget) begin step(); k++; end
    if (aborts < n) chk({tag, "_timeout"}, aborts, n);
  endtask

  // Monitor, UART busy model and requesters all act on the falling edge.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_busy   = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.req_ready !== (bus.tx_start ? bus.grant : 4'b0000)) ready_bad++;
      if (bus.tx_start) begin
        starts++;
        cur_bytes++;
        if (bus.tx_busy) busy_viol++;
        start_cyc.push_back(cyc);
        start_data.push_back(bus.tx_data);
        start_ready.push_back(bus.req_ready);
      end
      if (bus.pkt_abort) begin
        aborts++;
        abort_cyc = cyc;
      end
      if (bus.grant !== grant_prev) begin
        if (grant_prev != 4'b0000) seg_bytes.push_back(cur_bytes);
        if (bus.grant != 4'b0000) begin
          if (seen_grant) zrun_log.push_back(zrun);
          grant_log.push_back(bus.grant);
          grant_cyc.push_back(cyc);
          seen_grant = 1'b1;
        end
        cur_bytes = 0;
        zrun      = 0;
      end
      if (bus.grant == 4'b0000) zrun++;
      grant_prev = bus.grant;

      if (bus.tx_start) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      bus.tx_busy = (busy_cnt != 0);

      for (int i = 0; i < 4; i++) begin
        if (ready_prev[i] && rem[i] > 0) begin
          rem[i]--;
          sent[i]++;
        end
        v_n[i]         = (rem[i] > 0);
        d_n[8*i +: 8]  = seed[i] + 8'(sent[i]);
        l_n[i]         = (rem[i] > 0) && (last_every[i] || (last_final[i] && rem[i] == 1));
      end
      if (v_n != 4'b0000 && bus.req_valid == 4'b0000) valid_rise_cyc = cyc;
      bus.req_valid = v_n;
      bus.req_data  = d_n;
      bus.req_last  = l_n;
      ready_prev    = bus.req_ready;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_rr[5];
    logic [7:0] exp_rd[5];
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_rd = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h11};

    do_reset();
    chk("rst_grant",    bus.grant,     4'b0000);
    chk("rst_start",    bus.tx_start,  1'b0);
    chk("rst_ready",    bus.req_ready, 4'b0000);
    chk("rst_data",     bus.tx_data,   8'h00);
    chk("rst_abort",    bus.pkt_abort, 1'b0);

    // Single byte from requester 2.
    busy_len = 3;
    seed[2] = 8'h5A; last_final[2] = 1'b1; rem[2] = 1;
    wait_starts(1, 20, "single_start");
    wait_segs(1, 30, "single_rel");
    chk("single_grant",     grant_log[0], 4'b0100);
    chk("single_arb_lat",   grant_cyc[0] - valid_rise_cyc, 1);
    chk("single_start_lat", start_cyc[0] - grant_cyc[0], 1);
    chk("single_data",      start_data[0], 8'h5A);
    chk("single_ready",     start_ready[0], 4'b0100);
    chk("single_bytes",     seg_bytes[0], 1);

    // rr_ptr now 3: with 0 and 3 both valid, 3 goes first.
    seed[0] = 8'h01; last_final[0] = 1'b1; rem[0] = 1;
    seed[3] = 8'h03; last_final[3] = 1'b1; rem[3] = 1;
    wait_segs(3, 100, "ptr_rel");
    chk("ptr_grant1", grant_log[1], 4'b1000);
    chk("ptr_grant2", grant_log[2], 4'b0001);
    chk("ptr_gap0",   zrun_log[0], 5);
    chk("ptr_gap1",   zrun_log[1], 5);
    chk("ptr_data1",  start_data[1], 8'h03);
    chk("ptr_data2",  start_data[2], 8'h01);

    // Round robin, one byte per grant.
    do_reset();
    busy_len = 2;
    for (int i = 0; i < 4; i++) begin
      seed[i] = 8'(8'h10 * (i + 1)); last_every[i] = 1'b1; rem[i] = 2;
    end
    wait_segs(8, 400, "rr_rel");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant%0d", k), grant_log[k], exp_rr[k]);
      chk($sformatf("rr_data%0d", k),  start_data[k], exp_rd[k]);
    end
    for (int k = 0; k < 4; k++) chk($sformatf("rr_gap%0d", k), zrun_log[k], 5);

    // Packet limit: 70 bytes from 0 with no last, requester 1 waiting.
    do_reset();
    busy_len = 1;
    seed[0] = 8'h00; rem[0] = 70;
    seed[1] = 8'h80; last_final[1] = 1'b1; rem[1] = 3;
    wait_segs(3, 4000, "lim_rel");
    chk("lim_grant0", grant_log[0], 4'b0001);
    chk("lim_grant1", grant_log[1], 4'b0010);
    chk("lim_grant2", grant_log[2], 4'b0001);
    chk("lim_bytes0", seg_bytes[0], 64);
    chk("lim_bytes1", seg_bytes[1], 3);
    chk("lim_bytes2", seg_bytes[2], 6);
    chk("lim_byte64", start_data[63], 8'h3F);
    chk("lim_r1_first", start_data[64], 8'h80);
    chk("lim_r0_resume", start_data[67], 8'h40);
    chk("lim_aborts", aborts, 1);

    // Stall timeout on requester 3 after 2 bytes.
    do_reset();
    busy_len = 3;
    seed[3] = 8'hC0; rem[3] = 2;
    wait_aborts(1, 2000, "stall_abort");
    for (int k = 0; k < 50; k++) step();
    chk("stall_aborts",  aborts, 1);
    chk("stall_timing",  abort_cyc - start_cyc[1], 1028);
    chk("stall_starts",  starts, 2);
    chk("stall_grant",   grant_log[0], 4'b1000);
    chk("stall_ngrants", grant_log.size(), 1);
    chk("stall_release", bus.grant, 4'b0000);
    chk("stall_bytes",   seg_bytes[0], 2);

    // Backpressure: UART busy for 10 cycles per byte.
    do_reset();
    busy_len = 10;
    seed[1] = 8'h21; last_final[1] = 1'b1; rem[1] = 3;
    wait_segs(1, 200, "bp_rel");
    chk("bp_starts",   starts, 3);
    chk("bp_space01",  start_cyc[1] - start_cyc[0], 12);
    chk("bp_space12",  start_cyc[2] - start_cyc[1], 12);
    chk("bp_data2",    start_data[2], 8'h23);
    chk("bp_bytes",    seg_bytes[0], 3);

    // Reset during DRAIN of byte 2 of 5.
    do_reset();
    busy_len = 6;
    seed[0] = 8'h60; last_final[0] = 1'b1; rem[0] = 5;
    seed[2] = 8'h70; last_final[2] = 1'b1; rem[2] = 1;
    wait_starts(2, 100, "mid_start");
    step();
    rst = 1'b1;
    step();
    chk("mid_grant", bus.grant,     4'b0000);
    chk("mid_start", bus.tx_start,  1'b0);
    chk("mid_ready", bus.req_ready, 4'b0000);
    chk("mid_data",  bus.tx_data,   8'h00);
    chk("mid_abort", bus.pkt_abort, 1'b0);
    rst = 1'b0;
    clear_logs();
    wait_grants(1, 50, "mid_regrant");
    chk("mid_first_grant", grant_log[0], 4'b0001);
    wait_segs(2, 300, "mid_rel");
    chk("mid_resume_data", start_data[0], 8'h62);
    chk("mid_bytes",       seg_bytes[0], 3);
    chk("mid_next_grant",  grant_log[1], 4'b0100);

    chk("ready_vs_start",   ready_bad, 0);
    chk("start_while_busy", busy_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
